// File: rtl/config_field_sequencer.sv
// Configuration-mode controller for the RTC display: selects the field being edited,
// turns up/down buttons into single-cycle strobes with hold-to-repeat, and flags commit on exit.
module config_field_sequencer #(
    parameter int NUM_FIELDS    = 6,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_config,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] contadoresH,
    output logic       arriba,
    output logic       abajo,
    output logic       config_active,
    output logic       commit
);

    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int T_W   = $clog2(T_MAX + 1);

    localparam logic [3:0]     LAST_FIELD = 4'(NUM_FIELDS);
    localparam logic [T_W-1:0] T_DELAY    = T_W'(REPEAT_DELAY);
    localparam logic [T_W-1:0] T_PERIOD   = T_W'(REPEAT_PERIOD);
    localparam logic [T_W-1:0] T_ZERO     = T_W'(0);
    localparam logic [T_W-1:0] T_ONE      = T_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [4:0]     r_prev;
    logic [4:0]     w_btn;
    logic [4:0]     w_rise;
    logic [3:0]     r_field;
    logic [3:0]     w_field_nxt;
    logic [T_W-1:0] r_timer;
    logic [T_W-1:0] w_timer_nxt;
    logic           r_arriba;
    logic           r_abajo;
    logic           r_active;
    logic           r_commit;
    logic           w_arriba_nxt;
    logic           w_abajo_nxt;
    logic           w_active_nxt;
    logic           w_commit_nxt;

    // Bit order: config, left, right, up, down.
    assign w_btn  = {btn_config, btn_left, btn_right, btn_up, btn_down};
    assign w_rise = w_btn & ~r_prev;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, field selection and strobe generation.
    always_comb begin
        w_state_nxt  = r_state;
        w_field_nxt  = r_field;
        w_timer_nxt  = T_ZERO;
        w_arriba_nxt = 1'b0;
        w_abajo_nxt  = 1'b0;
        w_active_nxt = 1'b0;
        w_commit_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_field_nxt = 4'd0;
                if (w_rise[4]) begin
                    w_state_nxt  = S_EDIT;
                    w_field_nxt  = 4'd1;
                    w_active_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EDIT: begin
                w_active_nxt = 1'b1;
                if (w_rise[4]) begin
                    w_state_nxt  = S_COMMIT;
                    w_field_nxt  = 4'd0;
                    w_active_nxt = 1'b0;
                    w_commit_nxt = 1'b1;
                end else if (w_rise[3] ^ w_rise[2]) begin
                    // A field change leaves the timer at zero so a still-held button stays quiet.
                    if (w_rise[2]) begin
                        w_field_nxt = (r_field >= LAST_FIELD) ? 4'd1 : r_field + 4'd1;
                    end else begin
                        w_field_nxt = (r_field <= 4'd1) ? LAST_FIELD : r_field - 4'd1;
                    end
                end else if (btn_up ^ btn_down) begin
                    if (w_rise[1] | w_rise[0]) begin
                        w_arriba_nxt = btn_up;
                        w_abajo_nxt  = btn_down;
                        w_timer_nxt  = T_DELAY;
                    end else if (r_timer == T_ONE) begin
                        w_arriba_nxt = btn_up;
                        w_abajo_nxt  = btn_down;
                        w_timer_nxt  = T_PERIOD;
                    end else if (r_timer != T_ZERO) begin
                        w_timer_nxt = r_timer - T_ONE;
                    end else begin
                        w_timer_nxt = T_ZERO;
                    end
                end else begin
                    w_timer_nxt = T_ZERO;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
                w_field_nxt = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_field_nxt = 4'd0;
            end
        endcase
    end

    // Datapath and output registers; button history updates in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev   <= 5'd0;
            r_field  <= 4'd0;
            r_timer  <= T_ZERO;
            r_arriba <= 1'b0;
            r_abajo  <= 1'b0;
            r_active <= 1'b0;
            r_commit <= 1'b0;
        end else begin
            r_prev   <= w_btn;
            r_field  <= w_field_nxt;
            r_timer  <= w_timer_nxt;
            r_arriba <= w_arriba_nxt;
            r_abajo  <= w_abajo_nxt;
            r_active <= w_active_nxt;
            r_commit <= w_commit_nxt;
        end
    end

    assign contadoresH   = r_field;
    assign arriba        = r_arriba;
    assign abajo         = r_abajo;
    assign config_active = r_active;
    assign commit        = r_commit;

endmodule

// File: tb/tb_config_field_sequencer.sv
// Bench for config_field_sequencer: directed scenarios plus random button traffic,
// all checked against a cycle-numbered reference model.
module tb_config_field_sequencer;

    localparam int NF = 6;
    localparam int RD = 10;
    localparam int RP = 4;

    localparam logic [4:0] B_CFG = 5'b10000;
    localparam logic [4:0] B_L   = 5'b01000;
    localparam logic [4:0] B_R   = 5'b00100;
    localparam logic [4:0] B_UP  = 5'b00010;
    localparam logic [4:0] B_DN  = 5'b00001;
    localparam logic [4:0] B_NO  = 5'b00000;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_config, btn_left, btn_right, btn_up, btn_down;
    logic [3:0] contadoresH;
    logic       arriba, abajo, config_active, commit;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 edit, 2 commit; repeats scheduled by absolute sample number.
    int         m_mode;
    int         m_field;
    int         m_cyc;
    int         m_fire;
    logic [4:0] m_prev;
    logic       e_up, e_dn, e_commit;

    config_field_sequencer #(.NUM_FIELDS(NF), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset),
        .btn_config(btn_config), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down),
        .contadoresH(contadoresH), .arriba(arriba), .abajo(abajo),
        .config_active(config_active), .commit(commit)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_fire = -1; m_prev = 5'd0;
        e_up = 1'b0; e_dn = 1'b0; e_commit = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] b);
        logic [4:0] r;
        r = b & ~m_prev;
        e_up = 1'b0; e_dn = 1'b0; e_commit = 1'b0;
        if (m_mode == 0) begin
            if (r[4]) begin m_mode = 1; m_field = 1; end
        end else if (m_mode == 1) begin
            if (r[4]) begin
                m_mode = 2; m_field = 0; e_commit = 1'b1; m_fire = -1;
            end else if (r[3] != r[2]) begin
                if (r[2]) m_field = m_field % NF + 1;
                else      m_field = (m_field + NF - 2) % NF + 1;
                m_fire = -1;
            end else if (b[1] != b[0]) begin
                if (r[1] || r[0]) begin
                    e_up = b[1]; e_dn = b[0]; m_fire = m_cyc + RD;
                end else if (m_fire == m_cyc) begin
                    e_up = b[1]; e_dn = b[0]; m_fire = m_cyc + RP;
                end
            end else begin
                m_fire = -1;
            end
        end else begin
            m_mode = 0;
        end
        m_prev = b;
        m_cyc++;
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] f;
        f = (m_mode == 1) ? 4'(m_field) : 4'd0;
        return {f, e_up, e_dn, (m_mode == 1), e_commit};
    endfunction

    function automatic logic [7:0] act_vec();
        return {contadoresH, arriba, abajo, config_active, commit};
    endfunction

    task automatic drive(input logic [4:0] b);
        {btn_config, btn_left, btn_right, btn_up, btn_down} = b;
        @(posedge clk);
        model_step(b);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {btn_config, btn_left, btn_right, btn_up, btn_down} = B_NO;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (act_vec() !== 8'h00) begin
            n_err++; $display("FAIL reset_values: got %h want 00", act_vec());
        end
        reset = 1'b0;
        drive(B_NO);
        n_vec++;
        if (act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL idle_after_reset: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_enter();
        drive(B_CFG);
        n_vec++;
        if (contadoresH !== 4'd1 || config_active !== 1'b1 || arriba !== 1'b0 || abajo !== 1'b0 || commit !== 1'b0) begin
            n_err++; $display("FAIL enter_edit: got %h want 1:0:0:1:0", act_vec());
        end
        drive(B_NO);
        n_vec++;
        if (act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL enter_hold: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_navigate();
        int seq [6] = '{2, 3, 4, 5, 6, 1};
        for (int i = 0; i < 6; i++) begin
            drive(B_R);
            n_vec++;
            if (contadoresH !== 4'(seq[i]) || act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL right_step%0d: got %0d want %0d", i, contadoresH, seq[i]);
            end
            drive(B_NO);
        end
        drive(B_L);
        n_vec++;
        if (contadoresH !== 4'd6) begin
            n_err++; $display("FAIL left_wrap: got %0d want 6", contadoresH);
        end
        drive(B_NO);
        drive(B_L);
        drive(B_NO);
        n_vec++;
        if (contadoresH !== 4'd5) begin
            n_err++; $display("FAIL left_to5: got %0d want 5", contadoresH);
        end
    endtask

    task automatic test_hold_repeat();
        logic want;
        for (int i = 0; i < 20; i++) begin
            drive(B_UP);
            want = ((i + 1) == 1) || ((i + 1) == 11) || ((i + 1) == 15) || ((i + 1) == 19);
            n_vec++;
            if (arriba !== want || abajo !== 1'b0 || act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL hold_cycle%0d: got up=%b dn=%b want up=%b dn=0", i + 1, arriba, abajo, want);
            end
        end
        drive(B_NO);
        n_vec++;
        if (arriba !== 1'b0 || act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL hold_release: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_both();
        for (int i = 0; i < 15; i++) begin
            drive(B_UP | B_DN);
            n_vec++;
            if (arriba !== 1'b0 || abajo !== 1'b0) begin
                n_err++; $display("FAIL both_held%0d: got up=%b dn=%b want 0 0", i, arriba, abajo);
            end
        end
        for (int i = 0; i < 12; i++) begin
            drive(B_UP);
            n_vec++;
            if (arriba !== 1'b0 || abajo !== 1'b0 || act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL down_released%0d: got up=%b dn=%b want 0 0", i, arriba, abajo);
            end
        end
        drive(B_NO);
        drive(B_UP);
        n_vec++;
        if (arriba !== 1'b1 || abajo !== 1'b0) begin
            n_err++; $display("FAIL fresh_rise: got up=%b dn=%b want 1 0", arriba, abajo);
        end
        drive(B_NO);
    endtask

    task automatic test_nav_cancels();
        logic [3:0] want_f;
        for (int i = 0; i < 12; i++) begin
            drive((i == 6) ? (B_UP | B_R) : B_UP);
            want_f = (i < 6) ? 4'd5 : 4'd6;
            n_vec++;
            if (arriba !== (i == 0) || contadoresH !== want_f || act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL nav_cancel%0d: got up=%b fld=%0d want up=%b fld=%0d", i + 1, arriba, contadoresH, (i == 0), want_f);
            end
        end
        drive(B_NO);
    endtask

    task automatic test_commit();
        drive(B_CFG);
        n_vec++;
        if (commit !== 1'b1 || contadoresH !== 4'd0 || config_active !== 1'b0) begin
            n_err++; $display("FAIL commit_pulse: got %h want 00:0:0:0:1", act_vec());
        end
        drive(B_NO);
        n_vec++;
        if (commit !== 1'b0 || config_active !== 1'b0 || act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL commit_one_cycle: got %h want %h", act_vec(), exp_vec());
        end
        drive(B_CFG);
        drive(B_NO);
        drive(B_CFG);
        n_vec++;
        if (commit !== 1'b1) begin
            n_err++; $display("FAIL commit_again: got %b want 1", commit);
        end
        {btn_config, btn_left, btn_right, btn_up, btn_down} = B_NO;
        reset = 1'b1;
        #1;
        n_vec++;
        if (act_vec() !== 8'h00) begin
            n_err++; $display("FAIL reset_in_commit: got %h want 00", act_vec());
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(B_NO);
        drive(B_CFG);
        n_vec++;
        if (contadoresH !== 4'd1 || config_active !== 1'b1 || act_vec() !== exp_vec()) begin
            n_err++; $display("FAIL idle_after_commit_reset: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic [4:0] b;
        b = B_NO;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) b[4] = ~b[4];
            if ($urandom_range(0, 11) == 0) b[3] = ~b[3];
            if ($urandom_range(0, 11) == 0) b[2] = ~b[2];
            if ($urandom_range(0, 9)  == 0) b[1] = ~b[1];
            if ($urandom_range(0, 9)  == 0) b[0] = ~b[0];
            drive(b);
            n_vec++;
            if (act_vec() !== exp_vec() || (arriba && abajo)) begin
                n_err++; $display("FAIL random%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                #2;
                n_vec++;
                if (act_vec() !== 8'h00) begin
                    n_err++; $display("FAIL random_reset%0d: got %h want 00", i, act_vec());
                end
                reset = 1'b0;
                model_reset();
            end
        end
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        test_reset();
        test_enter();
        test_navigate();
        test_hold_repeat();
        test_both();
        test_nav_cancels();
        test_commit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/config_field_sequencer.md
Name: config_field_sequencer

Overview:
- Time/date configuration controller for the RTC display datapath.
- Owns configuration mode and field selection, and drives the shared field-select bus `contadoresH` seen by every field counter (seconds, minutes, hours, day, month, year, …).
- Converts level button inputs into single-cycle `arriba`/`abajo` strobes with hold-to-repeat, and emits a `commit` strobe on mode exit so the RTC writer can latch the edited values.

Parameters:
- NUM_FIELDS, 6, number of editable fields; valid field codes are 1..NUM_FIELDS, 0 = none selected.
- REPEAT_DELAY, 50_000_000, clock cycles a held up/down button must stay high before auto-repeat starts (0.5 s at 100 MHz).
- REPEAT_PERIOD, 25_000_000, clock cycles between auto-repeat strobes (4 Hz at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- btn_config  in  1  debounced, synchronous level; enter/exit configuration.
- btn_left  in  1  debounced level; previous field.
- btn_right  in  1  debounced level; next field.
- btn_up  in  1  debounced level; increment selected field.
- btn_down  in  1  debounced level; decrement selected field.
- contadoresH  out  4  selected field code; 0 outside EDIT.
- arriba  out  1  one-cycle increment strobe.
- abajo  out  1  one-cycle decrement strobe.
- config_active  out  1  high while in EDIT.
- commit  out  1  one-cycle strobe on exit from EDIT.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; previous-sample registers of all buttons 0; repeat timer 0.
- Edge detection: rise = button & ~prev; prev registered every cycle in all states.
- All outputs are registered. A strobe is asserted for the single cycle following the clock edge that first samples the button high.
- FSM states: IDLE, EDIT, COMMIT.
- IDLE:
  - `contadoresH`=0; `arriba`/`abajo`=0.
  - Rise of `btn_config` -> EDIT with `contadoresH`=1 and `config_active`=1.
  - All other buttons are ignored.
- EDIT, per cycle, priority `btn_config` > left/right > up/down:
  - Rise of `btn_config` -> COMMIT. No `arriba`/`abajo` that cycle.
  - Rise of `btn_right`: field+1, wrapping NUM_FIELDS -> 1.
  - Rise of `btn_left`: field-1, wrapping 1 -> NUM_FIELDS.
  - Simultaneous left and right rises: field unchanged.
  - Any field change clears the repeat timer and suppresses up/down strobes that cycle.
  - Up/down with exactly one of `btn_up`/`btn_down` high:
    - Rise gives an immediate strobe and loads the timer.
    - Held: next strobe at REPEAT_DELAY cycles after the first, then every REPEAT_PERIOD cycles while held.
    - Release clears the timer.
  - Both `btn_up` and `btn_down` high: no strobes; timer cleared. Releasing one does not produce a strobe until a fresh rise.
  - `arriba` and `abajo` are never high in the same cycle.
- COMMIT:
  - Lasts exactly one cycle: `commit`=1, `contadoresH`=0, `config_active`=0.
  - Then unconditionally -> IDLE.
  - Button edges during COMMIT are not acted on. Prev registers still update, so a button held through COMMIT does not re-trigger in IDLE.
- Timer width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1). The timer saturates-free reloads; no overflow is possible.
- Reset mid-operation: immediate return to reset values, including mid-repeat and during COMMIT. No `commit` pulse is emitted.
- `contadoresH` width is fixed at 4, so NUM_FIELDS ≤ 15.

Test Plan:
Bench parameters: REPEAT_DELAY=10, REPEAT_PERIOD=4, NUM_FIELDS=6.

1. Reset, then pulse `btn_config` one cycle -> `config_active`=1, `contadoresH`=1 from the next cycle; `arriba`=`abajo`=`commit`=0.
2. In EDIT, 6 separate one-cycle `btn_right` pulses -> `contadoresH` sequence 2,3,4,5,6,1. Then 1 `btn_left` pulse -> 6.
3. At field 5, hold `btn_up` for 20 cycles from cycle 0 -> `arriba` high in cycles 1, 11, 15, 19 only; `abajo` never high.
4. At field 5, `btn_up` and `btn_down` rise in the same cycle and are held 15 cycles -> no strobes. Release `btn_down` -> still no strobe. Release and re-press `btn_up` -> one `arriba`.
5. Hold `btn_up` for 12 cycles, pulse `btn_right` at cycle 6 -> `arriba` in cycle 1 only; field becomes 6; the repeat at cycle 11 is suppressed because the timer was cleared.
6. Pulse `btn_config` in EDIT -> `commit`=1 for exactly one cycle with `contadoresH`=0, then IDLE. Repeat the test with `reset` asserted during the COMMIT cycle -> `commit` drops immediately and the FSM is in IDLE.
